// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes,
// base opcodes, the canonical NOP, the field bundle and immediate helpers.
// The optional immediate range check is enabled by INSTR_ENC_RANGE_CHECK_EN.
package instr_encoder_pkg;

  // Instruction formats; codes 6 and 7 are reserved and always flagged.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Base opcodes, identical to the ones the decode stage matches on.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // func3 values that turn an OP-IMM into a shift-by-immediate.
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  // ADDI x0,x0,0 -- substituted for any bundle that cannot be encoded.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One field bundle as presented by the producer. fmt stays a plain
  // vector so the reserved codes can be carried and flagged.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } fields_t;

  // True for SLLI/SRLI/SRAI, whose immediate slot holds func7 + shamt.
  function automatic logic is_shift_imm(input logic [6:0] opcode,
                                        input logic [2:0] func3);
    return (opcode == OPC_OP_IMM) && ((func3 == F3_SLLI) || (func3 == F3_SRXI));
  endfunction

  // True when imm is the sign extension of its low 'bits' bits, i.e. all
  // bits from (bits-1) upward are identical.
  function automatic logic imm_fits(input logic [31:0] imm,
                                    input int unsigned bits);
    logic [31:0] mask;
    logic [31:0] hi;
    mask = 32'hFFFF_FFFF << (bits - 1);
    hi   = imm & mask;
    return (hi == 32'h0) || (hi == mask);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: one field bundle in, one 32-bit RV32I word plus an
// error flag out. Reserved formats always error. With
// INSTR_ENC_RANGE_CHECK_EN defined, immediates that do not fit their
// format also error; otherwise they are silently truncated.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  fields_t     i_fields,
  output logic [31:0] o_word,
  output logic        o_err
);

  logic [31:0] w_packed;
  logic        w_fmt_err;
  logic        w_rng_err;

  // Scatter the fields into the instruction word for the selected format.
  always_comb begin
    // NOTE: defaults first -- any path through the case that skipped an
    // assignment would otherwise infer a latch.
    w_packed  = NOP_INSTR;
    w_fmt_err = 1'b0;
    case (i_fields.fmt)
      FMT_R: w_packed = {i_fields.func7, i_fields.rs2, i_fields.rs1,
                         i_fields.func3, i_fields.rd, i_fields.opcode};
      FMT_I: begin
        if (is_shift_imm(i_fields.opcode, i_fields.func3)) begin
          w_packed = {i_fields.func7, i_fields.imm[4:0], i_fields.rs1,
                      i_fields.func3, i_fields.rd, i_fields.opcode};
        end else begin
          w_packed = {i_fields.imm[11:0], i_fields.rs1,
                      i_fields.func3, i_fields.rd, i_fields.opcode};
        end
      end
      FMT_S: w_packed = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1,
                         i_fields.func3, i_fields.imm[4:0], i_fields.opcode};
      FMT_B: w_packed = {i_fields.imm[12], i_fields.imm[10:5], i_fields.rs2,
                         i_fields.rs1, i_fields.func3, i_fields.imm[4:1],
                         i_fields.imm[11], i_fields.opcode};
      FMT_U: w_packed = {i_fields.imm[31:12], i_fields.rd, i_fields.opcode};
      FMT_J: w_packed = {i_fields.imm[20], i_fields.imm[10:1], i_fields.imm[11],
                         i_fields.imm[19:12], i_fields.rd, i_fields.opcode};
      default: w_fmt_err = 1'b1;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // Flag immediates that the selected format cannot represent exactly.
  always_comb begin
    w_rng_err = 1'b0;
    case (i_fields.fmt)
      FMT_I: begin
        if (is_shift_imm(i_fields.opcode, i_fields.func3)) begin
          w_rng_err = |i_fields.imm[31:5];
        end else begin
          w_rng_err = !imm_fits(i_fields.imm, 12);
        end
      end
      FMT_S:   w_rng_err = !imm_fits(i_fields.imm, 12);
      FMT_B:   w_rng_err = !imm_fits(i_fields.imm, 13) || i_fields.imm[0];
      FMT_U:   w_rng_err = |i_fields.imm[11:0];
      FMT_J:   w_rng_err = !imm_fits(i_fields.imm, 21) || i_fields.imm[0];
      default: w_rng_err = 1'b0;
    endcase
  end
`else
  assign w_rng_err = 1'b0;
`endif

  assign o_err  = w_fmt_err | w_rng_err;
  assign o_word = o_err ? NOP_INSTR : w_packed;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder, two-stage valid/ready pipeline.
// S1 holds the field bundle and packs it combinationally; S2 holds the
// finished word and error flag. out_addr is a byte counter that advances
// by ADDR_STEP on every output transfer (error words included) and wraps
// silently. INSTR_ENC_RANGE_CHECK_EN enables immediate range checking.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_func3,
  input  logic [6:0]  in_func7,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  fields_t     w_in_fields;
  logic        r_s1_valid;
  fields_t     r_s1;
  logic [31:0] w_s1_word;
  logic        w_s1_err;

  logic        r_s2_valid;
  logic [31:0] r_s2_word;
  logic        r_s2_err;
  logic [31:0] r_addr;

  logic        w_out_fire;
  logic        w_s2_advance;
  logic        w_s1_advance;

  assign w_in_fields = '{fmt:    in_fmt,
                         opcode: in_opcode,
                         func3:  in_func3,
                         func7:  in_func7,
                         rs1:    in_rs1,
                         rs2:    in_rs2,
                         rd:     in_rd,
                         imm:    in_imm};

  // S2 moves when empty or when its word leaves; S1 moves behind it or
  // whenever it is empty. in_ready is therefore combinational from
  // out_ready, which lets a full pipeline still stream one word per cycle.
  assign w_out_fire   = r_s2_valid && out_ready;
  assign w_s2_advance = !r_s2_valid || out_ready;
  assign w_s1_advance = w_s2_advance || !r_s1_valid;
  assign in_ready     = !r_s1_valid || w_s1_advance;

  // S1: capture the field bundle on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering. The data
    // fields are reset as well: out_instr must read zero during reset and
    // the pipeline is shallow enough that this costs nothing meaningful.
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_in_fields;
      end
    end
  end

  instr_pack u_pack (
    .i_fields (r_s1),
    .o_word   (w_s1_word),
    .o_err    (w_s1_err)
  );

  // S2: register the packed word and its error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_word  <= 32'h0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_word <= w_s1_word;
        r_s2_err  <= w_s1_err;
      end
    end
  end

  // Byte address of the word currently in S2; steps after each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= BASE_ADDR;
    end else if (w_out_fire) begin
      r_addr <= r_addr + ADDR_STEP;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_instr = r_s2_word;
  assign out_err   = r_s2_err;
  assign out_addr  = r_addr;

endmodule
